// File: rtl/fp_compare_unit_if.sv
// rtl/fp_compare_unit_if.sv - operand/result handshake bundle for fp_compare_unit
interface fp_compare_unit_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [1:0]   op;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         lt;
  logic         eq;
  logic         gt;
  logic         unordered;
  logic         nan;
  logic         inf;
  logic         subnormal;
  logic         snan;
  logic         clear_sticky;
  logic         sticky_invalid;
  logic         sticky_unordered;

  modport master (
    output x, y, op, in_valid, out_ready, clear_sticky,
    input  in_ready, out_valid, result, lt, eq, gt, unordered,
           nan, inf, subnormal, snan, sticky_invalid, sticky_unordered
  );

  modport slave (
    input  x, y, op, in_valid, out_ready, clear_sticky,
    output in_ready, out_valid, result, lt, eq, gt, unordered,
           nan, inf, subnormal, snan, sticky_invalid, sticky_unordered
  );
endinterface

// File: rtl/fp_compare_unit.sv
// rtl/fp_compare_unit.sv - two-stage IEEE compare / min / max / max-magnitude unit
// S1 holds operands and class flags, S2 holds relation, selected result and flags.
module fp_compare_unit #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_compare_unit_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  function automatic fp_class_t classify(input logic [W-1:0] v);
    fp_class_t      c;
    logic           e_ones;
    logic           e_zero;
    logic           m_zero;
    e_ones = &v[W-2:MAN_W];
    e_zero = ~|v[W-2:MAN_W];
    m_zero = ~|v[MAN_W-1:0];
    c.zero = e_zero & m_zero;
    c.sub  = e_zero & ~m_zero;
    c.inf  = e_ones & m_zero;
    c.nan  = e_ones & ~m_zero;
    c.snan = e_ones & ~m_zero & ~v[MAN_W-1];
    return c;
  endfunction

  logic         s1_valid;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_y;
  logic [1:0]   s1_op;
  fp_class_t    s1_xc;
  fp_class_t    s1_yc;

  logic         out_valid_q;
  logic [W-1:0] result_q;
  logic         lt_q, eq_q, gt_q, un_q;
  logic         nan_q, inf_q, sub_q, snan_q;
  logic         sticky_invalid_q;
  logic         sticky_unordered_q;

  logic s2_advance;
  logic in_ready_c;
  logic out_xfer;

  assign s2_advance = ~out_valid_q | bus.out_ready;
  assign in_ready_c = ~s1_valid | s2_advance;
  assign out_xfer   = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_op    <= 2'b00;
      s1_xc    <= '0;
      s1_yc    <= '0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x  <= bus.x;
        s1_y  <= bus.y;
        s1_op <= bus.op;
        s1_xc <= classify(bus.x);
        s1_yc <= classify(bus.y);
      end
    end
  end

  logic         x_sign, y_sign;
  logic         any_nan, both_zero;
  logic         mag_gt, mag_eq;
  logic         c_lt, c_eq, c_gt, c_un;
  logic [W-1:0] c_res;

  assign x_sign    = s1_x[W-1];
  assign y_sign    = s1_y[W-1];
  assign any_nan   = s1_xc.nan | s1_yc.nan;
  assign both_zero = s1_xc.zero & s1_yc.zero;
  assign mag_gt    = s1_x[W-2:0] > s1_y[W-2:0];
  assign mag_eq    = s1_x[W-2:0] == s1_y[W-2:0];

  // Magnitude order flips for negative operands; signed zeros are equal.
  always_comb begin
    c_lt = 1'b0;
    c_eq = 1'b0;
    c_gt = 1'b0;
    c_un = 1'b0;
    if (any_nan) begin
      c_un = 1'b1;
    end else if (both_zero || (mag_eq && x_sign == y_sign)) begin
      c_eq = 1'b1;
    end else if (x_sign != y_sign) begin
      c_lt = x_sign;
      c_gt = ~x_sign;
    end else if (x_sign) begin
      c_lt = mag_gt;
      c_gt = ~mag_gt;
    end else begin
      c_gt = mag_gt;
      c_lt = ~mag_gt;
    end
  end

  always_comb begin
    c_res = '0;
    if (s1_op != 2'b00) begin
      if (s1_xc.nan && s1_yc.nan) begin
        c_res = QNAN;
      end else if (s1_xc.nan) begin
        c_res = s1_y;
      end else if (s1_yc.nan) begin
        c_res = s1_x;
      end else if (both_zero) begin
        // min prefers -0, max and max-magnitude prefer +0
        case (s1_op)
          2'b01:   c_res = {x_sign | y_sign, {(W-1){1'b0}}};
          2'b10:   c_res = {x_sign & y_sign, {(W-1){1'b0}}};
          default: c_res = '0;
        endcase
      end else begin
        case (s1_op)
          2'b01:   c_res = c_gt ? s1_y : s1_x;
          2'b10:   c_res = c_lt ? s1_y : s1_x;
          default: c_res = (mag_gt || mag_eq) ? s1_x : s1_y;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q        <= 1'b0;
      result_q           <= '0;
      lt_q               <= 1'b0;
      eq_q               <= 1'b0;
      gt_q               <= 1'b0;
      un_q               <= 1'b0;
      nan_q              <= 1'b0;
      inf_q              <= 1'b0;
      sub_q              <= 1'b0;
      snan_q             <= 1'b0;
      sticky_invalid_q   <= 1'b0;
      sticky_unordered_q <= 1'b0;
    end else begin
      if (s2_advance) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          result_q <= c_res;
          lt_q     <= c_lt;
          eq_q     <= c_eq;
          gt_q     <= c_gt;
          un_q     <= c_un;
          nan_q    <= s1_xc.nan | s1_yc.nan;
          inf_q    <= s1_xc.inf | s1_yc.inf;
          sub_q    <= s1_xc.sub | s1_yc.sub;
          snan_q   <= s1_xc.snan | s1_yc.snan;
        end
      end
      // Events are accounted only when the flagged result is actually consumed.
      if (out_xfer) begin
        sticky_invalid_q   <= (sticky_invalid_q & ~bus.clear_sticky) | snan_q;
        sticky_unordered_q <= (sticky_unordered_q & ~bus.clear_sticky) | un_q;
      end else if (bus.clear_sticky) begin
        sticky_invalid_q   <= 1'b0;
        sticky_unordered_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready         = in_ready_c;
  assign bus.out_valid        = out_valid_q;
  assign bus.result           = result_q;
  assign bus.lt               = lt_q;
  assign bus.eq               = eq_q;
  assign bus.gt               = gt_q;
  assign bus.unordered        = un_q;
  assign bus.nan              = nan_q;
  assign bus.inf              = inf_q;
  assign bus.subnormal        = sub_q;
  assign bus.snan             = snan_q;
  assign bus.sticky_invalid   = sticky_invalid_q;
  assign bus.sticky_unordered = sticky_unordered_q;
endmodule

// File: tb/tb_fp_compare_unit.sv
// tb/tb_fp_compare_unit.sv - scoreboard bench for fp_compare_unit (half and single precision)
module tb_fp_compare_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_compare_unit_if #(.EXP_W(5), .MAN_W(10)) bus ();
  fp_compare_unit_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

  fp_compare_unit #(.EXP_W(5), .MAN_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fp_compare_unit #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  int vectors = 0;
  int miscompares = 0;

  // {result, lt, eq, gt, unordered, nan, inf, subnormal, snan}
  logic [23:0] q[$];
  // {result, lt, eq, gt, unordered}
  logic [35:0] q32[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] e(input logic [15:0] r, input logic [3:0] rel, input logic [3:0] cls);
    return {r, rel, cls};
  endfunction

  localparam logic [3:0] LT = 4'b1000, EQ = 4'b0100, GT = 4'b0010, UN = 4'b0001;
  localparam logic [3:0] C_NAN = 4'b1000, C_INF = 4'b0100, C_SUB = 4'b0010, C_SNAN = 4'b0001;

  // Called at a falling edge; returns at the falling edge after the input transfer.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op,
                      input logic [23:0] exp, input bit push);
    int n;
    bus.x = x;
    bus.y = y;
    bus.op = op;
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    if (push) q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin : monitor
    logic [23:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid && bus.out_ready) begin
        check("onehot_relation", 64'($countones({bus.lt, bus.eq, bus.gt, bus.unordered})), 64'd1);
        if (q.size() == 0) begin
          check("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
        end else begin
          exp = q.pop_front();
          check("result_flags",
                {40'd0, bus.result, bus.lt, bus.eq, bus.gt, bus.unordered,
                 bus.nan, bus.inf, bus.subnormal, bus.snan},
                {40'd0, exp});
        end
      end
    end
  end

  initial begin : monitor32
    logic [35:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (bus32.out_valid && bus32.out_ready) begin
        if (q32.size() == 0) begin
          check("unexpected_output32", {63'd0, bus32.out_valid}, 64'd0);
        end else begin
          exp = q32.pop_front();
          check("result32", {28'd0, bus32.result, bus32.lt, bus32.eq, bus32.gt, bus32.unordered},
                {28'd0, exp});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    bit seen;
    bus.x = '0; bus.y = '0; bus.op = 2'b00; bus.in_valid = 1'b0;
    bus.out_ready = 1'b1; bus.clear_sticky = 1'b0;
    bus32.x = '0; bus32.y = '0; bus32.op = 2'b00; bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1; bus32.clear_sticky = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs",
          {46'd0, bus.out_valid, bus.result, bus.lt, bus.eq, bus.gt, bus.unordered,
           bus.nan, bus.inf, bus.subnormal, bus.snan, bus.sticky_invalid, bus.sticky_unordered},
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);

    send(16'h3C00, 16'h4000, 2'b10, e(16'h4000, LT, 4'b0000), 1);
    send(16'h0000, 16'h8000, 2'b01, e(16'h8000, EQ, 4'b0000), 1);
    send(16'h0000, 16'h8000, 2'b10, e(16'h0000, EQ, 4'b0000), 1);
    bus.in_valid = 1'b0;
    drain();
    #2;
    check("sticky_quiet", {62'd0, bus.sticky_invalid, bus.sticky_unordered}, 64'd0);
    @(negedge clk);

    send(16'h7C01, 16'hBC00, 2'b01, e(16'hBC00, UN, C_NAN | C_SNAN), 1);
    bus.in_valid = 1'b0;
    drain();
    #2;
    check("sticky_set", {62'd0, bus.sticky_invalid, bus.sticky_unordered}, 64'd3);
    @(negedge clk);
    bus.clear_sticky = 1'b1;
    @(negedge clk);
    bus.clear_sticky = 1'b0;
    #2;
    check("sticky_cleared", {62'd0, bus.sticky_invalid, bus.sticky_unordered}, 64'd0);
    @(negedge clk);

    send(16'h7C00, 16'h7E00, 2'b10, e(16'h7C00, UN, C_NAN | C_INF), 1);
    send(16'h7E00, 16'h7E00, 2'b10, e(16'h7E00, UN, C_NAN), 1);
    send(16'hBC00, 16'hC000, 2'b00, e(16'h0000, GT, 4'b0000), 1);
    send(16'h0001, 16'h8001, 2'b01, e(16'h8001, GT, C_SUB), 1);
    send(16'hFC00, 16'h3C00, 2'b11, e(16'hFC00, LT, C_INF), 1);
    send(16'h8000, 16'h0000, 2'b11, e(16'h0000, EQ, 4'b0000), 1);
    send(16'hBC00, 16'h3C00, 2'b11, e(16'hBC00, LT, 4'b0000), 1);
    send(16'h7E00, 16'h7C01, 2'b01, e(16'h7E00, UN, C_NAN | C_SNAN), 1);
    send(16'h4000, 16'h3C00, 2'b01, e(16'h3C00, GT, 4'b0000), 1);
    send(16'hC000, 16'hBC00, 2'b10, e(16'hBC00, LT, 4'b0000), 1);
    send(16'h8000, 16'h0000, 2'b01, e(16'h8000, EQ, 4'b0000), 1);
    bus.in_valid = 1'b0;
    drain();
    @(negedge clk);

    // Back-pressure: four back-to-back inputs with the sink stalled for three cycles.
    bus.out_ready = 1'b0;
    fork
      begin
        send(16'h3C00, 16'h4000, 2'b10, e(16'h4000, LT, 4'b0000), 1);
        send(16'h4000, 16'h3C00, 2'b10, e(16'h4000, GT, 4'b0000), 1);
        send(16'h3C00, 16'h3C00, 2'b01, e(16'h3C00, EQ, 4'b0000), 1);
        send(16'hC000, 16'h4000, 2'b11, e(16'hC000, LT, 4'b0000), 1);
        bus.in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        #2;
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("stall_hold", {47'd0, bus.out_valid, bus.result}, {47'd0, 1'b1, 16'h4000});
        @(negedge clk);
        bus.out_ready = 1'b1;
        #2;
        check("stall_hold_late", {47'd0, bus.out_valid, bus.result}, {47'd0, 1'b1, 16'h4000});
      end
    join
    drain();
    @(negedge clk);

    // A transaction caught by reset must never appear at the output.
    bus.out_ready = 1'b0;
    send(16'h3C00, 16'h4000, 2'b10, 24'd0, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) seen = 1'b1;
    end
    check("reset_discard", {63'd0, seen}, 64'd0);
    @(negedge clk);

    bus32.x = 32'hBF800000;
    bus32.y = 32'hC0000000;
    bus32.op = 2'b11;
    bus32.in_valid = 1'b1;
    #1;
    check("in_ready32", {63'd0, bus32.in_ready}, 64'd1);
    q32.push_back({32'hC0000000, GT});
    @(negedge clk);
    bus32.in_valid = 1'b0;
    n = 0;
    while (q32.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q32.size() != 0) check("drain32_timeout", 64'(q32.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fp_compare_unit.md
FP_COMPARE_UNIT -- requirements
Module: fp_compare_unit

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, mantissa field width; W = 1+EXP_W+MAN_W (default 16, half precision).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports x, y  input  W each  operands {sign, exponent, mantissa}.
REQ-006 SHALL have port op  input  2  00 compare-only, 01 min, 10 max, 11 max-magnitude.
REQ-007 SHALL have ports in_valid input 1 / in_ready output 1  input handshake.
REQ-008 SHALL have ports out_valid output 1 / out_ready input 1  output handshake.
REQ-009 SHALL have port result  output  W  selected operand for op 01/10/11; zero for op 00.
REQ-010 SHALL have ports lt, eq, gt, unordered  output  1 each  IEEE ordered relation of x to y.
REQ-011 SHALL have ports nan, inf, subnormal, snan  output  1 each  OR of per-operand class flags.
REQ-012 SHALL have ports clear_sticky input 1; sticky_invalid, sticky_unordered output 1 each.

Function
REQ-013 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-014 Two pipeline stages: S1 registers operands, op and class flags; S2 registers relation, result, flags; latency 2 cycles with no stall.
REQ-015 in_ready = ~s1_valid | s2_advance; s2_advance = ~out_valid | out_ready; throughput one per cycle.
REQ-016 While out_valid & ~out_ready, all outputs except in_ready hold stable; S1 holds if S2 cannot accept.
REQ-017 Classes per operand: zero (exp=0, man=0), subnormal (exp=0, man!=0), inf (exp all ones, man=0), NaN (exp all ones, man!=0), sNaN (NaN with man MSB=0).
REQ-018 unordered=1 when either operand is NaN; then lt=eq=gt=0.
REQ-019 +0 and -0 compare equal (eq=1); otherwise ordering by sign, then exponent, then mantissa, with magnitude order reversed for negative operands.
REQ-020 Exactly one of lt, eq, gt, unordered is 1 whenever out_valid=1.
REQ-021 min/max: exactly one NaN operand returns the other; both NaN returns canonical qNaN {0, all ones, 1, zeros}.
REQ-022 min(-0,+0) in either order returns -0; max returns +0; equal non-zero operands return x.
REQ-023 op 11 compares |x| vs |y|, returns larger; tie returns x, except ±0 tie returns +0; NaN rules as REQ-021.
REQ-024 Stickies update only on output transfer: next = (sticky & ~clear_sticky) | event; sticky_invalid event = snan, sticky_unordered event = unordered.
REQ-025 clear_sticky without an output transfer clears stickies next cycle; same-cycle event sets them.

Reset
REQ-026 rst_n=0 at a rising edge clears s1_valid, out_valid, result, all flags and stickies to 0; in_ready=1 from the first cycle after reset.
REQ-027 Reset mid-operation discards in-flight transactions; no out_valid until a new input transfer.

Verification
REQ-028 x=0x3C00, y=0x4000, op=10, out_ready=1 -> 2 cycles later out_valid=1, lt=1, result=0x4000.
REQ-029 x=0x0000, y=0x8000, op=01 -> eq=1, result=0x8000; op=10 -> result=0x0000.
REQ-030 x=0x7C01, y=0xBC00, op=01 -> unordered=1, snan=1, nan=1, result=0xBC00, sticky_invalid=1 after transfer; clear_sticky pulse -> 0.
REQ-031 x=0x7C00, y=0x7E00, op=10 -> inf=1, nan=1, unordered=1, result=0x7C00; x=y=0x7E00 -> result=0x7E00.
REQ-032 Stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 delivered in order, none lost or duplicated.
REQ-033 EXP_W=8, MAN_W=23: x=0xBF800000, y=0xC0000000, op=11 -> gt=1, result=0xC0000000.
